// File: rtl/alarm_clock_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alarm_clock_pkg
//  Description : Shared types and constants for the alarm-clock input stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package alarm_clock_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HELD   = 2'd1,
        REPEAT = 2'd2
    } btn_state_t;

    // Defaults for a 50 MHz clock: 10 ms debounce, 500 ms delay, 100 ms rate
    localparam int c_CLK_FREQ_HZ             = 50_000_000;
    localparam int c_DEBOUNCE_CYCLES_DEF     = 500_000;
    localparam int c_REPEAT_DELAY_CYCLES_DEF = 25_000_000;
    localparam int c_REPEAT_RATE_CYCLES_DEF  = 5_000_000;
    localparam int c_N_BUTTONS_DEF           = 5;

    localparam int HOUR_PLUS = 0;
    localparam int MIN_PLUS  = 1;
    localparam int SEC_PLUS  = 2;
    localparam int MODE      = 3;
    localparam int ALARM_EN  = 4;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/button_conditioner_if.sv
`default_nettype none
// ============================================================================
//  Module      : button_conditioner_if
//  Description : Raw button inputs and conditioned button events.
//  Revision    : 1.0 - initial release
// ============================================================================
interface button_conditioner_if
    import alarm_clock_pkg::*;
#(
    parameter int N_BUTTONS = c_N_BUTTONS_DEF
);
    logic [N_BUTTONS-1:0] btn_raw;
    logic [N_BUTTONS-1:0] repeat_en;
    logic [N_BUTTONS-1:0] btn_level;
    logic [N_BUTTONS-1:0] btn_pulse;
    logic [N_BUTTONS-1:0] btn_release;

    modport master (
        output btn_raw, repeat_en,
        input  btn_level, btn_pulse, btn_release
    );

    modport slave (
        input  btn_raw, repeat_en,
        output btn_level, btn_pulse, btn_release
    );
endinterface
`default_nettype wire

// File: rtl/button_conditioner_channel.sv
`default_nettype none
// ============================================================================
//  Module      : button_channel
//  Description : One button: 2-flop sync, debounce, auto-repeat FSM.
//  Revision    : 1.0 - initial release
// ============================================================================
module button_channel
    import alarm_clock_pkg::*;
#(
    parameter int ACTIVE_LOW          = 1,
    parameter int DEBOUNCE_CYCLES     = c_DEBOUNCE_CYCLES_DEF,
    parameter int REPEAT_DELAY_CYCLES = c_REPEAT_DELAY_CYCLES_DEF,
    parameter int REPEAT_RATE_CYCLES  = c_REPEAT_RATE_CYCLES_DEF
) (
    input  wire logic clk,
    input  wire logic rst_n,
    input  wire logic i_btn_raw,
    input  wire logic i_repeat_en,
    output logic      o_btn_level,
    output logic      o_btn_pulse,
    output logic      o_btn_release
);
    localparam int c_DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int c_RPT_MAX = max_int(REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES);
    localparam int c_RPT_W   = $clog2(c_RPT_MAX + 1);

    localparam logic [c_DB_W-1:0]  c_DB_LAST    = c_DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_RPT_W-1:0] c_DELAY_LAST = c_RPT_W'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [c_RPT_W-1:0] c_RATE_LAST  = c_RPT_W'(REPEAT_RATE_CYCLES - 1);
    localparam logic               c_REL_LVL    = (ACTIVE_LOW != 0);

    localparam logic [1:0] c_ST_IDLE   = 2'(IDLE);
    localparam logic [1:0] c_ST_HELD   = 2'(HELD);
    localparam logic [1:0] c_ST_REPEAT = 2'(REPEAT);

    logic [1:0]         r_sync;
    logic               r_p;
    logic [1:0]         r_state;
    logic [c_DB_W-1:0]  r_db_cnt;
    logic [c_RPT_W-1:0] r_rpt_cnt;
    logic               r_level;
    logic               r_pulse;
    logic               r_release;

    logic               w_differ;
    logic               w_accept;
    logic [c_RPT_W-1:0] w_rpt_last;
    logic               w_rpt_fire;

    always_comb begin
        w_differ   = (r_p != r_level);
        w_accept   = w_differ && (r_db_cnt == c_DB_LAST);
        w_rpt_last = (r_state == c_ST_HELD) ? c_DELAY_LAST : c_RATE_LAST;
        w_rpt_fire = i_repeat_en && r_p && (r_state != c_ST_IDLE)
                     && (r_rpt_cnt == w_rpt_last);
    end

    // Sync flops reset to the released level so a button held through reset
    // must be debounced again from scratch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {2{c_REL_LVL}};
            r_p    <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_btn_raw};
            r_p    <= r_sync[1] ^ c_REL_LVL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_ST_IDLE;
            r_db_cnt  <= '0;
            r_rpt_cnt <= '0;
            r_level   <= 1'b0;
            r_pulse   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_pulse   <= 1'b0;
            r_release <= 1'b0;

            if (!w_differ || w_accept) r_db_cnt <= '0;
            else                       r_db_cnt <= r_db_cnt + 1'b1;

            case (r_state)
                c_ST_IDLE: begin
                    if (w_accept) begin
                        r_state   <= c_ST_HELD;
                        r_level   <= 1'b1;
                        r_pulse   <= 1'b1;
                        r_rpt_cnt <= '0;
                    end
                end
                default: begin
                    // Release acceptance takes priority over a repeat expiry.
                    if (w_accept) begin
                        r_state   <= c_ST_IDLE;
                        r_level   <= 1'b0;
                        r_release <= 1'b1;
                        r_rpt_cnt <= '0;
                    end else if (w_rpt_fire) begin
                        r_state   <= c_ST_REPEAT;
                        r_pulse   <= 1'b1;
                        r_rpt_cnt <= '0;
                    end else if (i_repeat_en && r_p) begin
                        r_rpt_cnt <= r_rpt_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign o_btn_level   = r_level;
    assign o_btn_pulse   = r_pulse;
    assign o_btn_release = r_release;

endmodule
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : button_conditioner
//  Description : Array of independent debounced, auto-repeating buttons.
//  Revision    : 1.0 - initial release
// ============================================================================
module button_conditioner
    import alarm_clock_pkg::*;
#(
    parameter int N_BUTTONS           = c_N_BUTTONS_DEF,
    parameter int ACTIVE_LOW          = 1,
    parameter int DEBOUNCE_CYCLES     = c_DEBOUNCE_CYCLES_DEF,
    parameter int REPEAT_DELAY_CYCLES = c_REPEAT_DELAY_CYCLES_DEF,
    parameter int REPEAT_RATE_CYCLES  = c_REPEAT_RATE_CYCLES_DEF
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    button_conditioner_if.slave bus
);
    for (genvar i = 0; i < N_BUTTONS; i++) begin : g_ch
        button_channel #(
            .ACTIVE_LOW          (ACTIVE_LOW),
            .DEBOUNCE_CYCLES     (DEBOUNCE_CYCLES),
            .REPEAT_DELAY_CYCLES (REPEAT_DELAY_CYCLES),
            .REPEAT_RATE_CYCLES  (REPEAT_RATE_CYCLES)
        ) u_ch (
            .clk           (clk),
            .rst_n         (rst_n),
            .i_btn_raw     (bus.btn_raw[i]),
            .i_repeat_en   (bus.repeat_en[i]),
            .o_btn_level   (bus.btn_level[i]),
            .o_btn_pulse   (bus.btn_pulse[i]),
            .o_btn_release (bus.btn_release[i])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_button_conditioner
//  Description : Directed self-checking bench for button_conditioner.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_button_conditioner;
    localparam int c_N = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    button_conditioner_if #(.N_BUTTONS(c_N)) bif ();

    button_conditioner #(
        .N_BUTTONS           (c_N),
        .ACTIVE_LOW          (1),
        .DEBOUNCE_CYCLES     (4),
        .REPEAT_DELAY_CYCLES (20),
        .REPEAT_RATE_CYCLES  (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Event log relative to the last clr(): cycle index of each observed edge.
    int cyc;
    int p_cnt   [c_N];
    int p_first [c_N];
    int r_cnt   [c_N];
    int r_first [c_N];
    int consec;
    int wch;
    int p_q[$];
    logic [c_N-1:0] prev_p, prev_r;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clr();
        cyc = 0;
        for (int c = 0; c < c_N; c++) begin
            p_cnt[c] = 0; p_first[c] = -1; r_cnt[c] = 0; r_first[c] = -1;
        end
        p_q.delete();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        for (int c = 0; c < c_N; c++) begin
            if (bif.btn_pulse[c]) begin
                p_cnt[c]++;
                if (p_first[c] < 0) p_first[c] = cyc;
                if (c == wch) p_q.push_back(cyc);
                if (prev_p[c]) consec++;
            end
            if (bif.btn_release[c]) begin
                r_cnt[c]++;
                if (r_first[c] < 0) r_first[c] = cyc;
                if (prev_r[c]) consec++;
            end
        end
        prev_p = bif.btn_pulse;
        prev_r = bif.btn_release;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        int tot_p, tot_r;
        consec = 0; wch = 2;
        prev_p = '0; prev_r = '0;
        clr();

        // Reset with all buttons released
        bif.btn_raw   = 5'b11111;
        bif.repeat_en = 5'b00000;
        rst_n = 1'b0;
        #23;
        check("rst_level",   32'(bif.btn_level),   32'd0);
        check("rst_pulse",   32'(bif.btn_pulse),   32'd0);
        check("rst_release", 32'(bif.btn_release), 32'd0);

        @(posedge clk); #1;
        rst_n = 1'b1;
        clr();
        steps(100);
        tot_p = 0; tot_r = 0;
        for (int c = 0; c < c_N; c++) begin tot_p += p_cnt[c]; tot_r += r_cnt[c]; end
        check("idle_pulses",   32'(tot_p), 32'd0);
        check("idle_releases", 32'(tot_r), 32'd0);
        check("idle_level",    32'(bif.btn_level), 32'd0);

        // Clean press on channel 0
        bif.btn_raw[0] = 1'b0;
        clr();
        steps(6);
        check("press_level_early", 32'(bif.btn_level[0]), 32'd0);
        step();
        check("press_pulse_t7", 32'(bif.btn_pulse[0]), 32'd1);
        check("press_level_t7", 32'(bif.btn_level[0]), 32'd1);
        steps(3);
        check("press_pulse_cnt",   32'(p_cnt[0]),   32'd1);
        check("press_pulse_first", 32'(p_first[0]), 32'd7);
        check("press_level_held",  32'(bif.btn_level[0]), 32'd1);
        bif.btn_raw[0] = 1'b1;
        clr();
        steps(12);
        check("rel_first",    32'(r_first[0]), 32'd7);
        check("rel_cnt",      32'(r_cnt[0]),   32'd1);
        check("rel_no_pulse", 32'(p_cnt[0]),   32'd0);
        check("rel_level",    32'(bif.btn_level[0]), 32'd0);

        // Bounce shorter than the debounce window on channel 1
        clr();
        bif.btn_raw[1] = 1'b0; steps(3);
        bif.btn_raw[1] = 1'b1; steps(1);
        bif.btn_raw[1] = 1'b0; steps(3);
        bif.btn_raw[1] = 1'b1; steps(20);
        check("bounce_pulses",   32'(p_cnt[1]), 32'd0);
        check("bounce_releases", 32'(r_cnt[1]), 32'd0);
        check("bounce_level",    32'(bif.btn_level[1]), 32'd0);

        // Auto-repeat on channel 2: press at 7, then 27, 35, 43, 51, 59
        bif.repeat_en[2] = 1'b1;
        wch = 2;
        clr();
        bif.btn_raw[2] = 1'b0;
        steps(60);
        check("rpt_count", 32'(p_q.size()), 32'd6);
        if (p_q.size() == 6) begin
            check("rpt_t0", 32'(p_q[0]), 32'd7);
            check("rpt_t1", 32'(p_q[1]), 32'd27);
            check("rpt_t2", 32'(p_q[2]), 32'd35);
            check("rpt_t3", 32'(p_q[3]), 32'd43);
            check("rpt_t5", 32'(p_q[5]), 32'd59);
        end
        bif.btn_raw[2] = 1'b1;
        clr();
        steps(12);
        check("rpt_rel_no_pulse", 32'(p_cnt[2]),   32'd0);
        check("rpt_rel_first",    32'(r_first[2]), 32'd7);
        bif.repeat_en[2] = 1'b0;

        // Release accepted exactly when the delay timer would have expired
        bif.repeat_en[4] = 1'b1;
        clr();
        bif.btn_raw[4] = 1'b0;
        steps(20);
        bif.btn_raw[4] = 1'b1;
        steps(12);
        check("coll_press_first", 32'(p_first[4]), 32'd7);
        check("coll_pulse_cnt",   32'(p_cnt[4]),   32'd1);
        check("coll_rel_first",   32'(r_first[4]), 32'd27);
        check("coll_rel_cnt",     32'(r_cnt[4]),   32'd1);
        bif.repeat_en[4] = 1'b0;

        // Simultaneous presses on channels 0 and 3
        clr();
        bif.btn_raw[0] = 1'b0;
        bif.btn_raw[3] = 1'b0;
        steps(7);
        check("conc_ch0_first", 32'(p_first[0]), 32'd7);
        check("conc_ch3_first", 32'(p_first[3]), 32'd7);
        steps(5);
        check("conc_level", 32'(bif.btn_level), 32'b01001);

        // Reset mid-hold clears outputs asynchronously, then re-accepts
        rst_n = 1'b0;
        #2;
        check("midrst_level", 32'(bif.btn_level), 32'd0);
        steps(2);
        rst_n = 1'b1;
        clr();
        steps(6);
        check("rearm_level_early", 32'(bif.btn_level[0]), 32'd0);
        step();
        check("rearm_level_t7", 32'(bif.btn_level), 32'b01001);
        check("rearm_pulse_t7", 32'(bif.btn_pulse), 32'b01001);

        bif.btn_raw = 5'b11111;
        steps(12);
        check("final_level", 32'(bif.btn_level), 32'd0);
        check("never_consecutive", 32'(consec), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/button_conditioner.md
# button_conditioner

Input-conditioning stage between the board push-buttons and the alarm-clock core. It synchronises and debounces each raw button and emits one-clock pulses for the core's set and toggle inputs: alarm hour/minute/second "plus", clock/alarm mode switch, and alarm on/off. It also generates auto-repeat pulses while a "plus" button is held. All core logic consumes these pulses on `clk` instead of clocking on raw button edges.

## Interface

Parameters:
- `N_BUTTONS`, default 5: number of independent channels.
- `ACTIVE_LOW`, default 1: 1 means a raw level of 0 is "pressed".
- `DEBOUNCE_CYCLES`, default 500_000: consecutive stable synced samples required to accept a change. Must be ≥ 2.
- `REPEAT_DELAY_CYCLES`, default 25_000_000: cycles from the press pulse to the first repeat pulse.
- `REPEAT_RATE_CYCLES`, default 5_000_000: cycles between subsequent repeat pulses. Must be ≥ 2.

Ports:
- `clk`, input, 1: system clock. Single clock domain.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `btn_raw`, input, N_BUTTONS: asynchronous raw button levels.
- `repeat_en`, input, N_BUTTONS: per-channel auto-repeat enable. Static or quasi-static.
- `btn_level`, output, N_BUTTONS: debounced level, 1 = pressed.
- `btn_pulse`, output, N_BUTTONS: one-cycle pulse on accepted press and on each repeat.
- `btn_release`, output, N_BUTTONS: one-cycle pulse on accepted release.

## Operation

- Each channel is independent and identical. There is no cross-channel interaction.
- Synchroniser: 2-flop chain per channel. Polarity is normalised after the chain, so `p` = 1 means pressed.
- Per-channel states:
  - IDLE
  - HELD
  - REPEAT
- Debounce counter, width `$clog2(DEBOUNCE_CYCLES+1)`:
  - Counts consecutive cycles in which `p` differs from the accepted level.
  - Clears to 0 on any cycle where `p` equals the accepted level.
- IDLE → HELD:
  - Occurs when the counter reaches DEBOUNCE_CYCLES−1 and `p` = 1.
  - Registers `btn_level` = 1 and `btn_pulse` = 1 for one cycle.
  - Clears the repeat timer.
- Repeat timer (only when `repeat_en` = 1):
  - In HELD, counts while `p` = 1. It freezes, without clearing, while a release debounce is pending (`p` = 0).
  - At REPEAT_DELAY_CYCLES: `btn_pulse` for one cycle, enter REPEAT, clear the timer.
  - In REPEAT: `btn_pulse` every REPEAT_RATE_CYCLES of `p` = 1, with the same freeze rule.
  - Timer width: `$clog2(max(REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES)+1)`.
- `repeat_en` low:
  - Channel stays in HELD and never repeats.
  - Deasserting `repeat_en` in REPEAT stops further pulses immediately. The state stays REPEAT until release.
- HELD/REPEAT → IDLE:
  - Occurs when the counter reaches DEBOUNCE_CYCLES−1 and `p` = 0.
  - `btn_level` = 0 and `btn_release` = 1 for one cycle.
  - No `btn_pulse` is emitted on release.
- Bounce: any return to the accepted level before acceptance clears the debounce counter. Glitches shorter than DEBOUNCE_CYCLES never produce a pulse.
- Simultaneous events in one cycle:
  - Repeat-timer expiry and release acceptance: release wins, with no `btn_pulse` that cycle.
  - Presses on several channels: each pulses independently, possibly in the same cycle.

## Timing

- Reset (`rst_n` = 0, asynchronous):
  - All outputs are 0; state is IDLE; counters are 0.
  - Synchroniser flops load the released level (1 if ACTIVE_LOW, else 0), so a button held through reset is accepted only after release-free debouncing post-reset.
- Reset deasserted mid-press: the channel restarts from IDLE. The press is accepted DEBOUNCE_CYCLES+3 cycles later if still held.
- Latency from a raw edge (stable thereafter) to the `btn_pulse`/`btn_level` rise: exactly DEBOUNCE_CYCLES+3 clk edges (2 sync, DEBOUNCE_CYCLES count, 1 output register).
- Release edge to `btn_release`/`btn_level` fall: also DEBOUNCE_CYCLES+3.
- First repeat pulse: REPEAT_DELAY_CYCLES cycles after the press pulse.
- Subsequent repeat pulses: every REPEAT_RATE_CYCLES cycles.
- All outputs are registered. `btn_pulse` and `btn_release` are never high for two consecutive cycles.

## Structure

- Shared package `alarm_clock_pkg`:
  - Channel state enum `btn_state_t` {IDLE, HELD, REPEAT}.
  - Default timing constants for a 50 MHz clock: 10 ms debounce, 500 ms repeat delay, 100 ms repeat rate.
  - Button index constants: HOUR_PLUS, MIN_PLUS, SEC_PLUS, MODE, ALARM_EN.
- Sub-module `button_channel`: one synchroniser, debounce counter, repeat timer and FSM. `button_conditioner` is a generate loop over `N_BUTTONS` instances.

## Test plan

Bench parameters: DEBOUNCE_CYCLES=4, REPEAT_DELAY_CYCLES=20, REPEAT_RATE_CYCLES=8, ACTIVE_LOW=1, N_BUTTONS=5.

- Reset check: hold `rst_n` = 0, drive `btn_raw` = 5'b11111 → all outputs 0. Release reset, keep inputs idle 100 cycles → no pulses.
- Clean press: `btn_raw[0]` 1→0, held 10 cycles, `repeat_en` = 0 → `btn_pulse[0]` high exactly one cycle, 7 edges after the change; `btn_level[0]` rises the same cycle. Release → `btn_release[0]` 7 edges after release.
- Bounce rejection: `btn_raw[1]` low for 3 cycles, high 1, low 3, high → zero pulses, `btn_level[1]` stays 0.
- Auto-repeat: `repeat_en[2]` = 1, hold `btn_raw[2]` low 60 cycles → press pulse at t0, repeats at t0+20, +28, +36, +44 …; release adds no extra `btn_pulse`.
- Release/repeat collision: arrange release acceptance on the same cycle as repeat expiry → only `btn_release` fires.
- Concurrency and reset mid-press: press channels 0 and 3 in the same cycle → both pulse in the same cycle. Then assert `rst_n` mid-hold → `btn_level` clears immediately; after deassert, re-acceptance occurs after exactly 7 edges.
